// File: rtl/riscv_freertos_top.sv
// Peripheral/interrupt shell for the FreeRTOS soft-core SoC: SPI loopback slave,
// UART echo with one holding register, mtimecmp interrupt and context-switch sequencer.
module riscv_freertos_top #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int CTX_WORDS = 16,
    parameter int NUM_TASKS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic        spi_cs_n,
    input  logic        uart_rx,
    output logic        uart_tx,
    input  logic [63:0] mtime,
    input  logic [63:0] mtimecmp
);
    localparam int BIT_CLKS  = CLK_HZ / BAUD;
    localparam int HALF_CLKS = (BIT_CLKS + 1) / 2;
    localparam int BW        = $clog2(BIT_CLKS);
    localparam int CW        = $clog2(CTX_WORDS + 1);
    localparam int TW        = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1;

    // {sclk, mosi, cs_n, rx}; reset to the idle levels so no false edges after reset
    logic [3:0] sync1_q, sync2_q;
    logic       sclk_s, mosi_s, cs_s, rx_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 4'b0011;
            sync2_q <= 4'b0011;
        end else begin
            sync1_q <= {spi_sclk, spi_mosi, spi_cs_n, uart_rx};
            sync2_q <= sync1_q;
        end
    end
    assign {sclk_s, mosi_s, cs_s, rx_s} = sync2_q;

    // ---------------- SPI mode-0 slave ----------------
    logic       sclk_prev_q, cs_prev_q;
    logic [2:0] spi_bit_q;
    logic [7:0] spi_sh_q, spi_tx_sh_q, spi_rx_byte;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            spi_bit_q   <= 3'd0;
            spi_sh_q    <= 8'd0;
            spi_tx_sh_q <= 8'd0;
            spi_rx_byte <= 8'd0;
        end else begin
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            if (cs_s) begin
                spi_bit_q <= 3'd0;
                spi_sh_q  <= 8'd0;
            end else if (cs_prev_q) begin
                spi_tx_sh_q <= spi_rx_byte;
            end else if (sclk_s && !sclk_prev_q) begin
                spi_sh_q  <= {spi_sh_q[6:0], mosi_s};
                spi_bit_q <= spi_bit_q + 3'd1;
                if (spi_bit_q == 3'd7)
                    spi_rx_byte <= {spi_sh_q[6:0], mosi_s};
            end else if (!sclk_s && sclk_prev_q) begin
                // bit counter back at 0 means a byte just completed: reload for the next one
                spi_tx_sh_q <= (spi_bit_q == 3'd0) ? spi_rx_byte : {spi_tx_sh_q[6:0], 1'b0};
            end
        end
    end
    assign spi_miso = ~cs_s & spi_tx_sh_q[7];

    // ---------------- UART receiver ----------------
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
    rx_st_t        rx_st_q;
    logic [BW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_sh_q;
    logic          rx_prev_q, rx_vld_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_st_q   <= R_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= 3'd0;
            rx_sh_q   <= 8'd0;
            rx_prev_q <= 1'b1;
            rx_vld_q  <= 1'b0;
        end else begin
            rx_prev_q <= rx_s;
            rx_vld_q  <= 1'b0;
            case (rx_st_q)
                R_IDLE: if (rx_prev_q && !rx_s) begin
                    rx_cnt_q <= '0;
                    rx_st_q  <= R_START;
                end
                R_START: if (rx_cnt_q == BW'(HALF_CLKS - 1)) begin
                    rx_cnt_q <= '0;
                    rx_bit_q <= 3'd0;
                    rx_st_q  <= rx_s ? R_IDLE : R_DATA;
                end else rx_cnt_q <= rx_cnt_q + BW'(1);
                R_DATA: if (rx_cnt_q == BW'(BIT_CLKS - 1)) begin
                    rx_cnt_q <= '0;
                    rx_sh_q  <= {rx_s, rx_sh_q[7:1]};
                    rx_bit_q <= rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_st_q <= R_STOP;
                end else rx_cnt_q <= rx_cnt_q + BW'(1);
                default: if (rx_cnt_q == BW'(BIT_CLKS - 1)) begin
                    rx_cnt_q <= '0;
                    rx_st_q  <= R_IDLE;
                    rx_vld_q <= rx_s;
                end else rx_cnt_q <= rx_cnt_q + BW'(1);
            endcase
        end
    end

    // ---------------- UART transmitter + holding register ----------------
    logic          tx_busy_q, uart_tx_q, hold_vld_q, tx_free;
    logic [BW-1:0] tx_cnt_q;
    logic [3:0]    tx_left_q;
    logic [8:0]    tx_sh_q;
    logic [7:0]    hold_q;

    // free in the last cycle of a stop bit so frames can go out back-to-back
    assign tx_free = !tx_busy_q || (tx_cnt_q == BW'(BIT_CLKS - 1) && tx_left_q == 4'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_busy_q  <= 1'b0;
            uart_tx_q  <= 1'b1;
            tx_cnt_q   <= '0;
            tx_left_q  <= 4'd0;
            tx_sh_q    <= 9'd0;
            hold_q     <= 8'd0;
            hold_vld_q <= 1'b0;
        end else begin
            if (tx_busy_q) begin
                if (tx_cnt_q == BW'(BIT_CLKS - 1)) begin
                    tx_cnt_q <= '0;
                    if (tx_left_q == 4'd0) tx_busy_q <= 1'b0;
                    else begin
                        uart_tx_q <= tx_sh_q[0];
                        tx_sh_q   <= {1'b1, tx_sh_q[8:1]};
                        tx_left_q <= tx_left_q - 4'd1;
                    end
                end else tx_cnt_q <= tx_cnt_q + BW'(1);
            end
            if (tx_free && (hold_vld_q || rx_vld_q)) begin
                tx_busy_q <= 1'b1;
                tx_cnt_q  <= '0;
                tx_left_q <= 4'd9;
                uart_tx_q <= 1'b0;
                tx_sh_q   <= {1'b1, hold_vld_q ? hold_q : rx_sh_q};
                if (hold_vld_q) begin
                    hold_vld_q <= rx_vld_q;
                    if (rx_vld_q) hold_q <= rx_sh_q;
                end
            end else if (rx_vld_q && !hold_vld_q) begin
                hold_q     <= rx_sh_q;
                hold_vld_q <= 1'b1;
            end
        end
    end
    assign uart_tx = uart_tx_q;

    // ---------------- Timer interrupt + context-switch sequencer ----------------
    typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_SAVE, S_SWITCH, S_RESTORE, S_DONE} seq_st_t;
    seq_st_t       state_q;
    logic [CW-1:0] ctx_cnt_q;
    logic [TW-1:0] current_task;
    logic          irq_q, ported, switched;

    always_ff @(posedge clk) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= (mtime >= mtimecmp);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ctx_cnt_q    <= '0;
            current_task <= '0;
            ported       <= 1'b0;
            switched     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (irq_q) begin
                    state_q <= S_ENTRY;
                    ported  <= 1'b1;
                end
                S_ENTRY: begin
                    state_q   <= S_SAVE;
                    ctx_cnt_q <= '0;
                end
                S_SAVE: if (ctx_cnt_q == CW'(CTX_WORDS - 1)) state_q <= S_SWITCH;
                        else ctx_cnt_q <= ctx_cnt_q + CW'(1);
                S_SWITCH: begin
                    current_task <= (current_task == TW'(NUM_TASKS - 1)) ? '0 : current_task + TW'(1);
                    ctx_cnt_q    <= '0;
                    state_q      <= S_RESTORE;
                end
                S_RESTORE: if (ctx_cnt_q == CW'(CTX_WORDS - 1)) begin
                    state_q  <= S_DONE;
                    switched <= 1'b1;
                end else ctx_cnt_q <= ctx_cnt_q + CW'(1);
                S_DONE: if (!irq_q) begin
                    ported   <= 1'b0;
                    switched <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_freertos_top.sv
// Directed bench for riscv_freertos_top: timer compare table, switch latency,
// reset abort, UART echo/holding/framing and SPI loopback sequences.
module tb_riscv_freertos_top;
    logic        clk = 1'b0;
    logic        rst_n, spi_sclk, spi_mosi, spi_cs_n, uart_rx;
    logic        spi_miso, uart_tx;
    logic [63:0] mtime, mtimecmp;
    int          passed = 0, total = 0;
    longint      cyc = 0;

    riscv_freertos_top dut (
        .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_cs_n(spi_cs_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .mtime(mtime), .mtimecmp(mtimecmp)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] mt;
        logic [63:0] cmp;
        logic        irq;
    } tvec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic uart_send(input logic [7:0] d, input logic stopv, input int stop_len);
        uart_rx = 1'b0;
        repeat (434) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (434) @(negedge clk);
        end
        uart_rx = stopv;
        repeat (stop_len) @(negedge clk);
        uart_rx = 1'b1;
        if (!stopv) repeat (434) @(negedge clk);
    endtask

    // Records the line level each clock from the start-bit edge and decodes at bit centres.
    task automatic uart_mon(input int tmo, output logic [7:0] b, output int slen,
                            output longint fall, output bit ok);
        bit lvl [4200];
        int t = 0;
        ok = 0; b = 8'd0; slen = 0; fall = 0;
        while (uart_tx === 1'b1 && t < tmo) begin
            @(negedge clk);
            t++;
        end
        if (t >= tmo) return;
        fall = cyc;
        for (int i = 0; i < 4200; i++) begin
            lvl[i] = uart_tx;
            @(negedge clk);
        end
        while (slen < 4200 && lvl[slen] == 1'b0) slen++;
        for (int k = 0; k < 8; k++) b[k] = lvl[217 + 434 * (k + 1)];
        ok = (lvl[217] == 1'b0) && (lvl[4123] == 1'b1);
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'd0;
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7 - i];
            repeat (4) @(negedge clk);
            rx = {rx[6:0], spi_miso};
            spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (8) @(negedge clk);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        tvec_t       tv [9];
        logic [7:0]  rb [3];
        int          sl [3];
        longint      fl [3];
        bit          okv [3];
        logic [7:0]  srx;
        int          hits;

        tv[0] = '{64'd0,                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        tv[1] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        tv[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        tv[3] = '{64'd1000,               64'd1000,                1'b1};
        tv[4] = '{64'd999,                64'd1000,                1'b0};
        tv[5] = '{64'h1_0000_0000,        64'h0_FFFF_FFFF,         1'b1};
        tv[6] = '{64'h0_FFFF_FFFF,        64'h1_0000_0000,         1'b0};
        tv[7] = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
        tv[8] = '{64'd0,                  64'd0,                   1'b1};

        rst_n = 1'b0; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; uart_rx = 1'b1;
        mtime = 64'd0; mtimecmp = '1;
        repeat (3) @(negedge clk);
        chk("rst_uart_tx", uart_tx, 1);
        chk("rst_spi_miso", spi_miso, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ported", dut.ported, 0);
        chk("rst_switched", dut.switched, 0);
        chk("rst_task", dut.current_task, 0);

        foreach (tv[i]) begin
            mtime = tv[i].mt; mtimecmp = tv[i].cmp;
            @(negedge clk);
            chk($sformatf("irq_vec%0d", i), dut.irq_q, tv[i].irq);
        end

        mtime = 64'd0; mtimecmp = '1; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hits = 0;
        for (int k = 0; k < 10000; k++) begin
            @(negedge clk);
            if (dut.irq_q || dut.ported || dut.switched) hits++;
            mtime = mtime + 64'd1;
        end
        chk("no_irq_10000", hits, 0);
        chk("idle_uart_tx", uart_tx, 1);

        for (int r = 0; r < 5; r++) begin
            mtimecmp = mtime + 64'd1000;
            for (int k = 1; k <= 1036; k++) begin
                @(negedge clk);
                if (k == 1001) chk("ported_early", dut.ported, 0);
                if (k == 1002) chk("ported_at_1002", dut.ported, 1);
                if (k == 1035) chk("switched_early", dut.switched, 0);
                if (k == 1036) begin
                    chk("switched_at_1036", dut.switched, 1);
                    chk("ported_with_switched", dut.ported, 1);
                    chk($sformatf("task_rep%0d", r), dut.current_task, (r + 1) % 4);
                end
                mtime = mtime + 64'd1;
            end
            mtimecmp = '1;
            @(negedge clk);
            chk("ported_hold_done", dut.ported, 1);
            @(negedge clk);
            chk("ported_clear", dut.ported, 0);
            chk("switched_clear", dut.switched, 0);
            repeat (3) @(negedge clk);
        end

        mtime = 64'd5; mtimecmp = 64'd5;
        repeat (5) @(negedge clk);
        chk("in_save", dut.state_q, 2);
        rst_n = 1'b0; mtimecmp = '1;
        @(negedge clk);
        chk("abort_state", dut.state_q, 0);
        chk("abort_ported", dut.ported, 0);
        chk("abort_task", dut.current_task, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        fork
            uart_send(8'h41, 1'b1, 434);
            uart_mon(6000, rb[0], sl[0], fl[0], okv[0]);
        join
        chk("echo_41_frame", okv[0], 1);
        chk("echo_41_data", rb[0], 8'h41);
        chk("echo_start_len", sl[0], 434);
        repeat (600) @(negedge clk);

        // shortened stop bits make the sender outrun TX, forcing use of the holding register
        fork
            begin
                uart_send(8'h41, 1'b1, 260);
                uart_send(8'h42, 1'b1, 260);
                uart_send(8'h43, 1'b1, 434);
            end
            begin
                uart_mon(6000, rb[0], sl[0], fl[0], okv[0]);
                uart_mon(6000, rb[1], sl[1], fl[1], okv[1]);
                uart_mon(6000, rb[2], sl[2], fl[2], okv[2]);
            end
        join
        chk("b2b_frames_ok", {okv[0], okv[1], okv[2]}, 3'b111);
        chk("b2b_data", {rb[0], rb[1], rb[2]}, 24'h414243);
        chk("b2b_gap1", fl[1] - fl[0], 4340);
        chk("b2b_gap2", fl[2] - fl[1], 4340);
        repeat (600) @(negedge clk);

        fork
            uart_send(8'h55, 1'b0, 434);
            uart_mon(6000, rb[0], sl[0], fl[0], okv[0]);
        join
        chk("framing_no_echo", fl[0], 0);

        spi_xfer(8'hA5, 8, srx);
        chk("spi_first_00", srx, 8'h00);
        chk("spi_miso_cs_high", spi_miso, 0);
        spi_xfer(8'h3C, 8, srx);
        chk("spi_second_A5", srx, 8'hA5);
        spi_xfer(8'hF0, 4, srx);
        chk("spi_partial_bits", srx, 8'h03);
        spi_xfer(8'h81, 8, srx);
        chk("spi_after_partial", srx, 8'h3C);
        spi_xfer(8'h00, 8, srx);
        chk("spi_realign", srx, 8'h81);
        chk("spi_rx_byte", dut.spi_rx_byte, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
